// File: rtl/load_store_unit.sv
// load_store_unit: turns byte/half/word loads and stores at any byte address into one or two
// word-aligned RAM cycles with byte enables, returning sign/zero-extended load data.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic [31:0] mem_a_o,
    output logic [31:0] mem_wd_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_wbe_o,
    input  logic [31:0] mem_rd_i
);
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, lo_q, lo_d, hi_q, hi_d, a_q, a_d, wd_q, wd_d;
    logic [1:0]  size_q, size_d;
    logic        we_q, we_d, uns_q, uns_d;
    logic [1:0]  off;
    logic [7:0]  lanemask;
    logic        split;
    logic [31:0] base, rsh, ext;
    logic [63:0] wide;

    assign off      = addr_q[1:0];
    assign lanemask = (size_q == 2'b00 ? 8'h01 : size_q == 2'b01 ? 8'h03 : 8'h0f) << off;
    assign split    = |lanemask[7:4];
    assign base     = {addr_q[31:2], 2'b00};
    // Low half feeds the first word cycle, high half the second.
    assign wide     = {32'b0, wdata_q} << {off, 3'b000};
    assign rsh      = 32'({hi_q, lo_q} >> {off, 3'b000});
    assign ext      = size_q == 2'b00 ? {{24{~uns_q & rsh[7]}}, rsh[7:0]} :
                      size_q == 2'b01 ? {{16{~uns_q & rsh[15]}}, rsh[15:0]} : rsh;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        we_d         = we_q;
        uns_d        = uns_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        a_d          = a_q;
        wd_d         = wd_q;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        resp_rdata_o = '0;
        mem_we_o     = 1'b0;
        mem_wbe_o    = '0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    size_d  = req_size_i;
                    we_d    = req_we_i;
                    uns_d   = req_unsigned_i;
                    hi_d    = '0;
                    state_d = ACC0;
                end
            end
            ACC0: begin
                a_d       = base;
                mem_we_o  = we_q;
                mem_wbe_o = we_q ? lanemask[3:0] : 4'b0000;
                wd_d      = we_q ? wide[31:0] : wd_q;
                lo_d      = we_q ? lo_q : mem_rd_i;
                state_d   = split ? ACC1 : RESP;
            end
            ACC1: begin
                a_d       = base + 32'd4;
                mem_we_o  = we_q;
                mem_wbe_o = we_q ? lanemask[7:4] : 4'b0000;
                wd_d      = we_q ? wide[63:32] : wd_q;
                hi_d      = we_q ? hi_q : mem_rd_i;
                state_d   = RESP;
            end
            default: begin
                resp_valid_o = 1'b1;
                resp_rdata_o = we_q ? '0 : ext;
                state_d      = IDLE;
            end
        endcase
        mem_a_o  = a_d;
        mem_wd_o = wd_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            a_q     <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            a_q     <= a_d;
            wd_q    <= wd_d;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench with a byte-addressed reference memory (64 bytes, aliased)
// driving directed and random loads/stores through a word RAM model.
module tb_load_store_unit;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid, req_ready, req_we, req_unsigned, resp_valid, mem_we;
    logic [31:0] req_addr, req_wdata, resp_rdata, mem_a, mem_wd, mem_rd;
    logic [1:0]  req_size;
    logic [3:0]  mem_wbe;
    logic [31:0] ram [16];
    logic        bd_we = 1'b0;
    logic [3:0]  bd_idx = '0;
    logic [31:0] bd_data = '0;
    logic [7:0]  mm [64];
    int          cyc = 0, checks = 0, errors = 0;
    typedef struct {logic [31:0] rdata; int cyc;} exp_t;
    exp_t        sbq[$];

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
        .req_wdata_i(req_wdata), .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata),
        .mem_a_o(mem_a), .mem_wd_o(mem_wd), .mem_we_o(mem_we), .mem_wbe_o(mem_wbe),
        .mem_rd_i(mem_rd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rd = ram[mem_a[5:2]];
    always @(posedge clk) begin
        if (bd_we) ram[bd_idx] <= bd_data;
        else if (mem_we)
            for (int l = 0; l < 4; l++)
                if (mem_wbe[l]) ram[mem_a[5:2]][8*l +: 8] <= mem_wd[8*l +: 8];
    end

    function automatic int nbytes(input logic [1:0] s);
        return s == 2'b00 ? 1 : s == 2'b01 ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] s, input logic u);
        int n;
        logic [31:0] v;
        n = nbytes(s);
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mm[6'(a + 32'(i))];
        if (!u && n < 4 && v[8*n-1]) for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] model_word(input int w);
        return {mm[4*w+3], mm[4*w+2], mm[4*w+1], mm[4*w]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int t = 0;
        while (req_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("accept", 32'(req_ready), 32'd1);
    endtask

    task automatic drain();
        int t = 0;
        while (sbq.size() > 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 32'(sbq.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected: got rdata %h with no request outstanding", resp_rdata);
                end else begin
                    e = sbq.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] a, input logic [1:0] s,
                         input logic u, input logic [31:0] wd);
        int n, off, nacc, d;
        logic [31:0] ea, ewd, m32;
        logic [3:0] ewbe;
        exp_t e;
        req_valid = 1'b1; req_we = we; req_addr = a; req_size = s; req_unsigned = u; req_wdata = wd;
        wait_ready();
        if (req_ready !== 1'b1) begin
            req_valid = 1'b0;
            return;
        end
        n = nbytes(s);
        off = int'(a[1:0]);
        nacc = (off + n > 4) ? 2 : 1;
        e.rdata = we ? 32'd0 : model_load(a, s, u);
        e.cyc = cyc + 1 + nacc;
        sbq.push_back(e);
        if (we) for (int i = 0; i < n; i++) mm[6'(a + 32'(i))] = wd[8*i +: 8];
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
        req_size = 2'($urandom); req_unsigned = 1'($urandom); req_wdata = $urandom;
        for (int j = 0; j < nacc; j++) begin
            if (j == 1) @(negedge clk);
            ea = {a[31:2], 2'b00} + 32'(4*j);
            ewbe = '0; ewd = '0; m32 = '0;
            if (we)
                for (int l = 0; l < 4; l++) begin
                    d = 4*j + l - off;
                    if (d >= 0 && d < n) begin
                        ewbe[l] = 1'b1;
                        ewd[8*l +: 8] = wd[8*d +: 8];
                        m32[8*l +: 8] = 8'hff;
                    end
                end
            chk("acc_addr", mem_a, ea);
            chk("acc_we_wbe", 32'({mem_we, mem_wbe}), 32'({we, ewbe}));
            chk("acc_wdata", mem_wd & m32, ewd);
        end
    endtask

    initial begin
        logic [31:0] a;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0; req_unsigned = 1'b0; req_wdata = '0;
        fork monitor(); join_none
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_we_wbe", 32'({mem_we, mem_wbe}), 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        for (int w = 0; w < 16; w++) begin
            @(negedge clk);
            bd_we = 1'b1;
            bd_idx = 4'(w);
            bd_data = w == 0 ? 32'h88776655 : w == 1 ? 32'hCCBBAA99 : 32'h0;
            for (int b = 0; b < 4; b++) mm[4*w+b] = bd_data[8*b +: 8];
        end
        @(negedge clk);
        bd_we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        issue(1'b0, 32'h0, 2'b10, 1'b0, '0);
        issue(1'b0, 32'h3, 2'b00, 1'b0, '0);
        issue(1'b0, 32'h3, 2'b00, 1'b1, '0);
        issue(1'b0, 32'h1, 2'b01, 1'b1, '0);
        issue(1'b0, 32'h2, 2'b10, 1'b0, '0);
        issue(1'b1, 32'h3, 2'b01, 1'b0, 32'h00001234);
        drain();
        chk("sh_word0", ram[0], 32'h34776655);
        chk("sh_word4", ram[1], 32'hCCBBAA12);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h6; req_size = 2'b10; req_wdata = 32'hDEADBEEF;
        wait_ready();
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_acc0_addr", mem_a, 32'h4);
        @(negedge clk);
        chk("abort_acc1_we", 32'(mem_we), 32'd1);
        chk("abort_acc1_addr", mem_a, 32'h8);
        #1 rst = 1'b1;
        #1;
        chk("abort_we_wbe", 32'({mem_we, mem_wbe}), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_mem_a", mem_a, 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        mm[6] = 8'hEF;
        mm[7] = 8'hBE;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready_after", 32'(req_ready), 32'd1);
        chk("abort_word4", ram[1], model_word(1));
        chk("abort_word8", ram[2], model_word(2));
        issue(1'b0, 32'hFFFFFFFE, 2'b10, 1'b0, '0);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0; req_size = 2'b10; req_unsigned = 1'b0;
        @(negedge clk);
        chk("ready_in_resp", 32'(req_ready), 32'd0);
        issue(1'b0, 32'h0, 2'b10, 1'b0, '0);
        issue(1'b0, 32'h5, 2'b11, 1'b0, '0);
        issue(1'b1, 32'h9, 2'b11, 1'b0, 32'hA1B2C3D4);
        issue(1'b0, 32'h9, 2'b11, 1'b1, '0);
        for (int k = 0; k < 300; k++) begin
            a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a = a | 32'hFFFFFFC0;
            issue(1'($urandom), a, 2'($urandom), 1'($urandom), $urandom);
        end
        drain();
        for (int w = 0; w < 16; w++) chk("ram_word", ram[w], model_word(w));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
